// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder scheduler: FSM encoding, counter width and
// the id-width helper.
package adder_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   // Wide enough for the largest supported latency (15).
   localparam int unsigned CntW = 4;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after
// (last_grant+1) mod NREQ.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IdW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IdW-1:0]  last_grant,
   output logic [IdW-1:0]  grant_idx,
   output logic            any_grant
);

   int unsigned     idx;
   logic [NREQ-1:0] rot;

   always_comb begin
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      rot       = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(last_grant) + k) % NREQ;
         rot = req >> idx;
         if (!any_grant && rot[0]) begin
            any_grant = 1'b1;
            grant_idx = IdW'(idx);
         end
      end
   end

endmodule

// File: rtl/adder_sched.sv
// Time-shares one external adder among NREQ requesters, one transaction in
// flight at a time, with round-robin grant order.
module adder_sched
   import adder_sched_pkg::*;
#(
   parameter int unsigned M    = 32,
   parameter int unsigned N    = 16,
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 1,
   localparam int unsigned IdW = clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*M-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [M-1:0]      add_in,
   input  logic [N-1:0]      add_out,
   output logic              rsp_valid,
   output logic [IdW-1:0]    rsp_id,
   output logic [N-1:0]      rsp_data,
   input  logic              rsp_ready
);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [M-1:0]    add_in_q, add_in_d;
   logic [N-1:0]    rsp_data_q, rsp_data_d;
   logic [IdW-1:0]  rsp_id_q, rsp_id_d;
   logic [IdW-1:0]  last_grant_q, last_grant_d;
   logic [IdW-1:0]  grant_idx;
   logic            any_grant;

   rr_arbiter #(
      .NREQ (NREQ),
      .IdW  (IdW)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant_idx  (grant_idx),
      .any_grant  (any_grant)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      add_in_d     = add_in_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;
      unique case (state_q)
         StIdle: begin
            if (any_grant) begin
               req_ready    = NREQ'(1) << grant_idx;
               add_in_d     = req_data[grant_idx*M +: M];
               cnt_d        = CntW'(LAT);
               last_grant_d = grant_idx;
               state_d      = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q <= CntW'(1)) begin
               cnt_d      = '0;
               rsp_data_d = add_out;
               rsp_id_d   = last_grant_q;
               state_d    = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // The grant is combinational off req_valid, so mask it while held in reset.
      if (!rst_n) req_ready = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         add_in_q     <= '0;
         rsp_data_q   <= '0;
         rsp_id_q     <= '0;
         last_grant_q <= IdW'(NREQ - 1);
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         add_in_q     <= add_in_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign add_in    = add_in_q;
   assign rsp_valid = (state_q == StResp);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched with a combinational adder model
// (add_out = low half + high half of add_in).
module tb_adder_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic [31:0]  add_in;
   logic [15:0]  add_out;
   logic         rsp_valid;
   logic [1:0]   rsp_id;
   logic [15:0]  rsp_data;
   logic         rsp_ready;

   int n_cmp = 0;
   int n_err = 0;

   int          ord[5]  = '{0, 1, 2, 3, 0};
   logic [15:0] sums[4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

   adder_sched #(
      .M    (32),
      .N    (16),
      .NREQ (4),
      .LAT  (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .add_in    (add_in),
      .add_out   (add_out),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready)
   );

   assign add_out = add_in[15:0] + add_in[31:16];

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      n_cmp++; if (add_in !== 32'h0) begin n_err++; $display("FAIL reset_add_in: got %h want 0", add_in); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
      n_cmp++; if (rsp_data !== 16'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      n_cmp++; if (add_in !== 32'h0001_0010) begin n_err++; $display("FAIL reset_add_in_load: got %h want 00010010", add_in); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h0011) begin
         n_err++; $display("FAIL reset_first_rsp: got v=%b id=%0d d=%h want v=1 id=0 d=0011", rsp_valid, rsp_id, rsp_data);
      end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      req_data[95:64] = 32'h0003_0005;
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_accept: got %b want 0100", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: got %b want 0", rsp_valid); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL single_wait: got ready=%b v=%b want ready=0000 v=0", req_ready, rsp_valid);
      end
      n_cmp++; if (add_in !== 32'h0003_0005) begin n_err++; $display("FAIL single_add_in: got %h want 00030005", add_in); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 16'h0008) begin
         n_err++; $display("FAIL single_rsp: got v=%b id=%0d d=%h want v=1 id=2 d=0008", rsp_valid, rsp_id, rsp_data);
      end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         n_err++; $display("FAIL single_done: got v=%b ready=%b want v=0 ready=0000", rsp_valid, req_ready);
      end
      req_data[95:64] = 32'h0003_0030;
   endtask

   task automatic test_fairness();
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_cmp++; if (req_ready !== 4'(1 << ord[k])) begin
            n_err++; $display("FAIL fair_grant_%0d: got %b want %b", k, req_ready, 4'(1 << ord[k]));
         end
         @(negedge clk);
         n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL fair_wait_%0d: got ready=%b v=%b want 0000/0", k, req_ready, rsp_valid);
         end
         @(negedge clk);
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(ord[k]) || rsp_data !== sums[ord[k]]) begin
            n_err++; $display("FAIL fair_rsp_%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                              k, rsp_valid, rsp_id, rsp_data, ord[k], sums[ord[k]]);
         end
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_backpressure();
      @(posedge clk); #1;
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_accept: got %b want 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b1111;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_wait_ready: got %b want 0000", req_ready); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0022 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL bp_hold_%0d: got v=%b id=%0d d=%h ready=%b want v=1 id=1 d=0022 ready=0000",
                              i, rsp_valid, rsp_id, rsp_data, req_ready);
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
         n_err++; $display("FAIL bp_release: got v=%b ready=%b want v=1 ready=0000", rsp_valid, req_ready);
      end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
         n_err++; $display("FAIL bp_after: got v=%b ready=%b want v=0 ready=0100", rsp_valid, req_ready);
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_abort();
      @(posedge clk); #1;
      req_valid = 4'b0010;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL abort_accept: got %b want 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || add_in !== 32'h0 || req_ready !== 4'b0000) begin
         n_err++; $display("FAIL abort_reset: got v=%b add_in=%h ready=%b want 0/0/0000", rsp_valid, add_in, req_ready);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_rsp_%0d: got %b want 0", i, rsp_valid); end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_valid = 4'b0010;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL abort_regrant: got %b want 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0022) begin
         n_err++; $display("FAIL abort_rsp: got v=%b id=%0d d=%h want v=1 id=1 d=0022", rsp_valid, rsp_id, rsp_data);
      end
   endtask

   task automatic test_withdraw();
      @(posedge clk); #1;
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_accept: got %b want 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(posedge clk); #1;
      req_valid = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL wd_resp_%0d: got ready=%b v=%b want ready=0000 v=1", i, req_ready, rsp_valid);
         end
      end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL wd_release: got %b want 0000", req_ready); end
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL wd_idle: got ready=%b v=%b want ready=0000 v=0", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      req_valid = 4'b0001;
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_next_grant: got %b want 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 16'h0011) begin
         n_err++; $display("FAIL wd_rsp: got v=%b id=%0d d=%h want v=1 id=0 d=0011", rsp_valid, rsp_id, rsp_data);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      req_data  = {32'h0004_0040, 32'h0003_0030, 32'h0002_0020, 32'h0001_0010};
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_abort();
      test_withdraw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
